// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, issue FSM states and control-code check
// Purpose: constants and helpers shared by the ALU command front-end.
// Contents: ALU_AND/ALU_OR/ALU_ADD/ALU_NOR control codes, state_t, is_valid_ctrl().
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_valid_ctrl(input logic [3:0] ctrl);
    logic ok;
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_NOR: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc (count one event), clear (sync zero),
//        count (current value, STAT_W bits).
module sat_counter #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clear,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - command/response front-end driving a registered-control 32-bit ALU
// Purpose: accepts one ALU operation at a time, holds operands/control on the ALU,
//          waits ALU_LAT edges after the ALU samples control, then returns the result.
// Ports: cmd_* (valid/ready command in), alu_* (operands/control out, results in),
//        resp_* (valid/ready response out), stat_ops/stat_err (saturating counters).
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_src1,
  input  logic [DATA_W-1:0] cmd_src2,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_cout,
  output logic              resp_overflow,
  output logic              resp_err,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_err
);

  localparam int CNT_W = 3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             ctrl_ok;
  logic             handoff;
  logic             capture;

  // In RESP a new command is taken on the same edge the response leaves.
  assign cmd_ready  = rst_n && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
  assign resp_valid = (state_q == RESP);
  assign accept     = cmd_valid && cmd_ready;
  assign ctrl_ok    = is_valid_ctrl(cmd_ctrl);
  assign handoff    = resp_valid && resp_ready;
  assign capture    = (state_q == EXEC) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ctrl_ok ? EXEC : RESP;
      end
      EXEC: begin
        if (capture) state_d = RESP;
      end
      RESP: begin
        if (handoff) begin
          if (accept) state_d = ctrl_ok ? EXEC : RESP;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag is parked in tag_q so resp_tag only changes at the capture edge,
  // keeping an outgoing response intact when the next command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src1      <= '0;
      alu_src2      <= '0;
      alu_ctrl      <= '0;
      tag_q         <= '0;
      cnt_q         <= '0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_cout     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_err      <= 1'b0;
      resp_tag      <= '0;
    end else begin
      if (accept && ctrl_ok) begin
        alu_src1 <= cmd_src1;
        alu_src2 <= cmd_src2;
        alu_ctrl <= cmd_ctrl;
        tag_q    <= cmd_tag;
        cnt_q    <= CNT_W'(ALU_LAT);
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      // Bad control codes never reach the ALU; the error response is formed at once.
      if (accept && !ctrl_ok) begin
        resp_result   <= '0;
        resp_zero     <= 1'b0;
        resp_cout     <= 1'b0;
        resp_overflow <= 1'b0;
        resp_err      <= 1'b1;
        resp_tag      <= cmd_tag;
      end else if (capture) begin
        resp_result   <= alu_result;
        resp_zero     <= alu_zero;
        resp_cout     <= alu_cout;
        resp_overflow <= alu_overflow;
        resp_err      <= 1'b0;
        resp_tag      <= tag_q;
      end
    end
  end

  sat_counter #(.STAT_W(STAT_W)) u_stat_ops (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handoff),
    .clear (1'b0),
    .count (stat_ops)
  );

  sat_counter #(.STAT_W(STAT_W)) u_stat_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handoff && resp_err),
    .clear (1'b0),
    .count (stat_err)
  );

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb/tb_alu_cmd_issue.sv - self-checking bench for alu_cmd_issue with a registered-control ALU model
module tb_alu_cmd_issue;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src1;
  logic [31:0] cmd_src2;
  logic [3:0]  cmd_ctrl;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        alu_overflow;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_cout;
  logic        resp_overflow;
  logic        resp_err;
  logic [3:0]  resp_tag;
  logic [15:0] stat_ops;
  logic [15:0] stat_err;

  int checks   = 0;
  int failures = 0;

  alu_cmd_issue #(
    .DATA_W(32), .CTRL_W(4), .ALU_LAT(1), .TAG_W(4), .STAT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_ctrl(cmd_ctrl), .cmd_tag(cmd_tag),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_cout(resp_cout),
    .resp_overflow(resp_overflow), .resp_err(resp_err), .resp_tag(resp_tag),
    .stat_ops(stat_ops), .stat_err(stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // What an operation must produce, straight from the opcode definitions.
  function automatic resp_t model_op(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] t);
    resp_t r;
    logic [32:0] s;
    r = '0;
    r.tag = t;
    case (c)
      4'b0000: r.result = a & b;
      4'b0001: r.result = a | b;
      4'b0010: begin
        s        = {1'b0, a} + {1'b0, b};
        r.result = s[31:0];
        r.cout   = s[32];
        r.ovf    = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b1100: r.result = ~(a | b);
      default: r.err = 1'b1;
    endcase
    if (!r.err) r.zero = (r.result == 32'd0);
    return r;
  endfunction

  function automatic logic [15:0] sat16(input longint v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  // ALU with a control/operand register: samples the edge after the DUT drives it.
  logic [31:0] a_r = '0, b_r = '0;
  logic [3:0]  c_r = '0;
  resp_t       alu_m;
  always @(posedge clk) begin
    a_r <= alu_src1;
    b_r <= alu_src2;
    c_r <= alu_ctrl;
  end
  assign alu_m        = model_op(c_r, a_r, b_r, 4'd0);
  assign alu_result   = alu_m.result;
  assign alu_zero     = alu_m.zero;
  assign alu_cout     = alu_m.cout;
  assign alu_overflow = alu_m.ovf;

  // Scoreboard: expected responses in accept order, counters by handoffs seen.
  resp_t  exp_q[$];
  resp_t  got_q[$];
  resp_t  cur, prev_resp, e;
  logic   prev_hold = 1'b0;
  longint model_ops = 0, model_err = 0;
  longint ops_base  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_ops = 0;
      model_err = 0;
      prev_hold = 1'b0;
    end else begin
      cur = {resp_result, resp_zero, resp_cout, resp_overflow, resp_err, resp_tag};
      chk("stat_ops", stat_ops, sat16(ops_base + model_ops));
      chk("stat_err", stat_err, sat16(model_err));
      if (prev_hold) begin
        chk("resp_hold_valid", resp_valid, 1);
        chk("resp_hold_data", cur, prev_resp);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", cur, e);
          model_ops++;
          if (e.err) model_err++;
        end
        got_q.push_back(cur);
      end
      prev_hold = resp_valid && !resp_ready;
      prev_resp = cur;
      if (cmd_valid && cmd_ready)
        exp_q.push_back(model_op(cmd_ctrl, cmd_src1, cmd_src2, cmd_tag));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, output int n);
    cmd_valid = 1'b1;
    cmd_ctrl  = c;
    cmd_src1  = a;
    cmd_src2  = b;
    cmd_tag   = t;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Returns on the first falling edge with resp_valid high; e = falling edges skipped.
  task automatic wait_resp(output int e_cnt);
    e_cnt = 0;
    @(negedge clk);
    while (!resp_valid && e_cnt < 50) begin
      e_cnt++;
      @(negedge clk);
    end
    chk("resp_timeout", resp_valid, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int n, ed;

  initial begin
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_src1   = '0;
    cmd_src2   = '0;
    cmd_ctrl   = '0;
    cmd_tag    = '0;
    resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_alu_src1", alu_src1, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_stat_ops", stat_ops, 0);
    chk("rst_resp_tag", resp_tag, 0);
    step();
    rst_n = 1'b1;

    // ADD wrap-around: zero and carry both set, two edges of latency.
    resp_ready = 1'b1;
    send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, n);
    chk("t1_idle_accept_wait", n, 0);
    wait_resp(ed);
    chk("t1_latency", ed, 2);
    chk("t1_result", resp_result, 32'h0);
    chk("t1_zero", resp_zero, 1);
    chk("t1_cout", resp_cout, 1);
    chk("t1_err", resp_err, 0);
    chk("t1_tag", resp_tag, 3);
    step();

    // Back-to-back AND then NOR; second accept lands on the first handoff edge.
    send(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd1, n);
    send(4'b1100, 32'h0, 32'h0, 4'd2, n);
    chk("t2_accept_on_handoff", n, 2);
    wait_resp(ed);
    chk("t2_latency", ed, 2);
    step();
    chk("t2_count", got_q.size(), 3);
    chk("t2_and_result", got_q[1].result, 32'h0);
    chk("t2_and_zero", got_q[1].zero, 1);
    chk("t2_nor_result", got_q[2].result, 32'hFFFF_FFFF);
    chk("t2_nor_zero", got_q[2].zero, 0);
    chk("t2_stat_ops", stat_ops, 16'd3);

    // Unsupported code: immediate error response, ALU control untouched.
    send(4'b0111, 32'hAAAA_AAAA, 32'h5555_5555, 4'd9, n);
    wait_resp(ed);
    chk("t3_latency", ed, 0);
    chk("t3_err", resp_err, 1);
    chk("t3_result", resp_result, 32'h0);
    chk("t3_tag", resp_tag, 9);
    chk("t3_alu_ctrl_kept", alu_ctrl, 4'b1100);
    step();
    chk("t3_stat_err", stat_err, 16'd1);

    // OR with backpressure for five cycles, handoff on the sixth.
    resp_ready = 1'b0;
    send(4'b0001, 32'h1234_0000, 32'h0000_5678, 4'd5, n);
    wait_resp(ed);
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", resp_valid, 1);
      chk("t4_cmd_ready", cmd_ready, 0);
      chk("t4_result", resp_result, 32'h1234_5678);
      if (i < 4) @(negedge clk);
    end
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_handoff_valid", resp_valid, 1);
    chk("t4_handoff_ready", cmd_ready, 1);
    step();
    @(negedge clk);
    chk("t4_after_valid", resp_valid, 0);
    step();

    // Reset while executing: everything back to reset values, no response.
    send(4'b0010, 32'd1, 32'd2, 4'd7, n);
    rst_n = 1'b0;
    #1;
    chk("t5_cmd_ready", cmd_ready, 0);
    chk("t5_resp_valid", resp_valid, 0);
    chk("t5_alu_src1", alu_src1, 0);
    chk("t5_alu_src2", alu_src2, 0);
    chk("t5_alu_ctrl", alu_ctrl, 0);
    chk("t5_resp_result", resp_result, 0);
    chk("t5_resp_tag", resp_tag, 0);
    chk("t5_stat_ops", stat_ops, 0);
    chk("t5_stat_err", stat_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_resp", resp_valid, 0);
    end
    step();

    // Saturation: preload 0xFFFE, three more completions must stop at 0xFFFF.
    force dut.u_stat_ops.cnt_q = 16'hFFFE;
    ops_base = 65534;
    #1 release dut.u_stat_ops.cnt_q;
    chk("t6_preset", stat_ops, 16'hFFFE);
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 4'd4, n);
    wait_resp(ed);
    chk("t6_add_ovf", resp_overflow, 1);
    step();
    chk("t6_ops_1", stat_ops, 16'hFFFF);
    send(4'b0001, 32'h0000_00F0, 32'h0000_000F, 4'd6, n);
    wait_resp(ed);
    step();
    send(4'b0000, 32'hFFFF_0000, 32'h00FF_FF00, 4'd8, n);
    wait_resp(ed);
    chk("t6_and_result", resp_result, 32'h00FF_0000);
    step();
    chk("t6_ops_sat", stat_ops, 16'hFFFF);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
